// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared bus widths, constants and FSM encoding for the fetch stage
package if_fetch_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 64;
  localparam logic [InstBus-1:0] ZeroDoubleWord = '0;
  localparam logic ChipEnable = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic [InstAddrBus-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  function automatic logic misaligned(input logic [2:0] lsb);
    return |lsb;
  endfunction
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: memory, control, IF/ID and status signals of the fetch stage
interface if_fetch_if import if_fetch_pkg::*; #(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus
);
  logic              ce_o;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] inst_i;
  logic              stall_i;
  logic              branch_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              flush_i;
  logic [ADDR_W-1:0] flush_pc_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              id_valid_o;
  logic              fault_o;
  modport master (
    output ce_o, pc_o, id_pc_o, id_inst_o, id_valid_o, fault_o,
    input  inst_i, stall_i, branch_i, branch_target_i, flush_i, flush_pc_i
  );
  modport slave (
    input  ce_o, pc_o, id_pc_o, id_inst_o, id_valid_o, fault_o,
    output inst_i, stall_i, branch_i, branch_target_i, flush_i, flush_pc_i
  );
endinterface

// File: rtl/if_fetch_if_id.sv
// if_id: IF/ID pipeline register with clear (squash) over load, otherwise hold
module if_id import if_fetch_pkg::*; #(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_valid
);
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_valid;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_pc    <= '0;
      r_inst  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_inst  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_inst  <= i_inst;
      r_valid <= 1'b1;
    end
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_valid = r_valid;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC owner and fetch FSM; redirect priority is flush > branch > stall > advance
module if_fetch import if_fetch_pkg::*; #(
  parameter int                ADDR_W   = InstAddrBus,
  parameter int                INST_W   = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int                PC_STEP  = 8
) (
  input logic           clk,
  input logic           rst,
  if_fetch_if.master    bus
);
  state_t            r_state;
  logic              r_ce;
  logic              r_fault;
  logic [ADDR_W-1:0] r_pc;
  logic              w_run;
  logic              w_redir;
  logic [ADDR_W-1:0] w_target;
  assign w_run    = r_state == RUN;
  assign w_redir  = bus.flush_i | bus.branch_i;
  assign w_target = bus.flush_i ? bus.flush_pc_i : bus.branch_target_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= BOOT;
      r_ce    <= ChipDisable;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else if (r_state == BOOT) begin
      r_state <= RUN;
      r_ce    <= ChipEnable;
    end else if (w_run && w_redir) begin
      r_pc <= w_target;
      if (misaligned(w_target[2:0])) begin
        r_state <= HALT;
        r_ce    <= ChipDisable;
        r_fault <= 1'b1;
      end
    end else if (w_run && !bus.stall_i) begin
      r_pc <= r_pc + ADDR_W'(PC_STEP);
    end
  // a redirect squashes the word fetched this cycle, including a faulting one
  if_id #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_run & ~w_redir & ~bus.stall_i),
    .i_clear (w_run & w_redir),
    .i_pc    (r_pc),
    .i_inst  (bus.inst_i),
    .o_pc    (bus.id_pc_o),
    .o_inst  (bus.id_inst_o),
    .o_valid (bus.id_valid_o)
  );
  assign bus.ce_o    = r_ce;
  assign bus.pc_o    = r_pc;
  assign bus.fault_o = r_fault;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed stimulus against a behavioural fetch model plus literal spot checks
module tb_if_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  bit done = 1'b0;
  logic [63:0] rom [32];
  if_fetch_if #(.ADDR_W(32), .INST_W(64)) bus();
  if_fetch #(.ADDR_W(32), .INST_W(64), .RESET_PC(32'h0), .PC_STEP(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  assign bus.inst_i = bus.ce_o ? rom[bus.pc_o[7:3]] : 64'h0;

  // model: started/halted flags, PC and IF/ID contents derived from the rules
  bit          m_started, m_halted, m_fault, m_idv;
  logic [31:0] m_pc, m_idpc;
  logic [63:0] m_idinst;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_started <= 0; m_halted <= 0; m_fault <= 0; m_idv <= 0;
      m_pc <= 32'h0; m_idpc <= 32'h0; m_idinst <= 64'h0;
    end else if (!m_started) begin
      m_started <= 1;
    end else if (!m_halted) begin
      if (bus.flush_i || bus.branch_i) begin
        m_pc <= bus.flush_i ? bus.flush_pc_i : bus.branch_target_i;
        m_idv <= 0;
        m_idinst <= 64'h0;
        if (((bus.flush_i ? bus.flush_pc_i : bus.branch_target_i) % 8) != 0) begin
          m_halted <= 1;
          m_fault <= 1;
        end
      end else if (!bus.stall_i) begin
        m_idpc <= m_pc;
        m_idinst <= rom[m_pc[7:3]];
        m_idv <= 1;
        m_pc <= m_pc + 32'd8;
      end
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (!done) begin
    chk("m_ce", 64'(bus.ce_o), 64'(m_started && !m_halted));
    chk("m_pc", 64'(bus.pc_o), 64'(m_pc));
    chk("m_id_pc", 64'(bus.id_pc_o), 64'(m_idpc));
    chk("m_id_inst", bus.id_inst_o, m_idinst);
    chk("m_id_valid", 64'(bus.id_valid_o), 64'(m_idv));
    chk("m_fault", 64'(bus.fault_o), 64'(m_fault));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic ctl(input bit f, input logic [31:0] fpc, input bit b, input logic [31:0] bt, input bit s);
    bus.flush_i = f; bus.flush_pc_i = fpc;
    bus.branch_i = b; bus.branch_target_i = bt;
    bus.stall_i = s;
  endtask

  initial begin
    rom[0] = 64'h2080_8000_000f_0000;
    rom[1] = 64'h2091_0000_0000_2800;
    for (int i = 2; i < 32; i++) rom[i] = 64'hA000_0000_0000_0000 + 64'(i);
    ctl(0, 0, 0, 0, 0);
    repeat (2) step();
    chk("rst_pc", 64'(bus.pc_o), 64'h0);
    chk("rst_ce", 64'(bus.ce_o), 64'h0);
    chk("rst_valid", 64'(bus.id_valid_o), 64'h0);
    chk("rst_fault", 64'(bus.fault_o), 64'h0);
    rst = 1'b1;
    step();
    chk("boot_ce_on", 64'(bus.ce_o), 64'h1);
    chk("boot_pc", 64'(bus.pc_o), 64'h0);
    step();
    chk("w0_inst", bus.id_inst_o, 64'h2080_8000_000f_0000);
    chk("w0_pc", 64'(bus.id_pc_o), 64'h0);
    step();
    chk("w1_inst", bus.id_inst_o, 64'h2091_0000_0000_2800);
    chk("w1_pc", 64'(bus.id_pc_o), 64'h8);
    chk("pc_10", 64'(bus.pc_o), 64'h10);
    ctl(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 64'(bus.pc_o), 64'h10);
      chk("stall_id_pc", 64'(bus.id_pc_o), 64'h8);
    end
    ctl(0, 0, 0, 0, 0);
    step();
    chk("unstall_inst", bus.id_inst_o, 64'hA000_0000_0000_0002);
    chk("unstall_id_pc", 64'(bus.id_pc_o), 64'h10);
    ctl(1, 32'h10, 0, 0, 0);
    step();
    ctl(0, 0, 1, 32'h20, 0);
    step();
    chk("br_valid", 64'(bus.id_valid_o), 64'h0);
    chk("br_pc", 64'(bus.pc_o), 64'h20);
    ctl(0, 0, 0, 0, 0);
    step();
    chk("br_id_pc", 64'(bus.id_pc_o), 64'h20);
    chk("br_id_valid", 64'(bus.id_valid_o), 64'h1);
    chk("br_id_inst", bus.id_inst_o, 64'hA000_0000_0000_0004);
    ctl(1, 32'h0, 1, 32'h18, 1);
    step();
    chk("flush_wins_pc", 64'(bus.pc_o), 64'h0);
    chk("flush_valid", 64'(bus.id_valid_o), 64'h0);
    ctl(0, 0, 0, 0, 0);
    repeat (2) step();
    ctl(1, 32'hFFFF_FFF8, 0, 0, 0);
    step();
    chk("top_pc", 64'(bus.pc_o), 64'hFFFF_FFF8);
    ctl(0, 0, 0, 0, 0);
    step();
    chk("wrap_pc", 64'(bus.pc_o), 64'h0);
    chk("wrap_id_pc", 64'(bus.id_pc_o), 64'hFFFF_FFF8);
    step();
    chk("wrap_pc2", 64'(bus.pc_o), 64'h8);
    ctl(0, 0, 0, 0, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_pc", 64'(bus.pc_o), 64'h0);
    chk("arst_ce", 64'(bus.ce_o), 64'h0);
    chk("arst_id_pc", 64'(bus.id_pc_o), 64'h0);
    chk("arst_id_inst", bus.id_inst_o, 64'h0);
    chk("arst_valid", 64'(bus.id_valid_o), 64'h0);
    step();
    rst = 1'b1;
    ctl(0, 0, 0, 0, 0);
    repeat (2) step();
    ctl(0, 0, 1, 32'h0C, 0);
    step();
    chk("mis_fault", 64'(bus.fault_o), 64'h1);
    chk("mis_ce", 64'(bus.ce_o), 64'h0);
    chk("mis_pc", 64'(bus.pc_o), 64'h0C);
    chk("mis_valid", 64'(bus.id_valid_o), 64'h0);
    ctl(1, 32'h40, 1, 32'h20, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_fault", 64'(bus.fault_o), 64'h1);
      chk("halt_ce", 64'(bus.ce_o), 64'h0);
      chk("halt_pc", 64'(bus.pc_o), 64'h0C);
    end
    #2 rst = 1'b0;
    #1;
    chk("clr_fault", 64'(bus.fault_o), 64'h0);
    chk("clr_ce", 64'(bus.ce_o), 64'h0);
    chk("clr_pc", 64'(bus.pc_o), 64'h0);
    step();
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch initiator for the 64-bit CPU pipeline. Owns the program counter. Drives chip-enable and byte address to the combinational instruction ROM, and captures the returned 64-bit word into the IF/ID pipeline register. Handles stall, branch redirect, flush, and misaligned-target fault. Sits between the pipeline controller/ID stage and the instruction memory.

## Interface
Parameters:
- `ADDR_W`, default 32: PC / instruction address width (`InstAddrBus`).
- `INST_W`, default 64: instruction width (`InstBus`).
- `RESET_PC`, default 32'h0000_0000: first fetch address; must be 8-byte aligned.
- `PC_STEP`, default 8: byte increment per instruction.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in, 1 bit: clock; all state updates on the rising edge.
  - `rst` in, 1 bit: asynchronous, active-low reset.
- Instruction memory side:
  - `ce_o` out, 1 bit: instruction memory chip enable (`ChipEnable`/`ChipDisable`).
  - `pc_o` out, `ADDR_W` bits: fetch byte address; memory indexes with bits above [2:0].
  - `inst_i` in, `INST_W` bits: instruction word. It is combinational from `ce_o`/`pc_o` and is zero when `ce_o` is disabled.
- Control side:
  - `stall_i` in, 1 bit: controller stall; hold the PC and the IF/ID register.
  - `branch_i` in, 1 bit: taken branch from ID.
  - `branch_target_i` in, `ADDR_W` bits: branch target.
  - `flush_i` in, 1 bit: exception/pipeline flush.
  - `flush_pc_i` in, `ADDR_W` bits: flush redirect address.
- ID side:
  - `id_pc_o` out, `ADDR_W` bits: PC of the instruction held in IF/ID.
  - `id_inst_o` out, `INST_W` bits: instruction held in IF/ID.
  - `id_valid_o` out, 1 bit: IF/ID holds a real instruction.
- Status:
  - `fault_o` out, 1 bit: sticky misaligned-redirect fault.

## Operation
- FSM has three states: BOOT, RUN, HALT.
- BOOT (entered on reset):
  - `ce_o`=0, `pc_o`=`RESET_PC`.
  - First edge with `rst` high moves to RUN. `pc_o` is unchanged.
- RUN:
  - `ce_o`=1.
  - Priority per edge: flush > branch > stall > advance.
- Advance (no stall, branch or flush):
  - `id_pc_o`<=`pc_o`, `id_inst_o`<=`inst_i`, `id_valid_o`<=1.
  - `pc_o`<=`pc_o`+`PC_STEP`, modulo 2^`ADDR_W`. 32'hFFFF_FFF8 wraps to 0.
- Stall: `pc_o`, `id_pc_o`, `id_inst_o` and `id_valid_o` all hold.
- Branch (asserted without flush):
  - `pc_o`<=`branch_target_i`.
  - The word fetched this cycle is squashed: `id_valid_o`<=0, `id_inst_o`<=`ZeroDoubleWord`.
  - There is no delay slot.
  - Branch overrides a simultaneous stall.
- Flush: same as branch, using `flush_pc_i`. Overrides branch and stall.
- Misaligned redirect: if the selected redirect address has bits [2:0] ≠ 0:
  - Go to HALT. `fault_o`<=1, `ce_o`=0, `id_valid_o`<=0.
  - `pc_o` latches the offending address.
- HALT:
  - All outputs hold; `fault_o` is sticky.
  - Only reset exits HALT.
- Reset values, applied immediately on `rst` low, including mid-operation:
  - `ce_o`=0, `pc_o`=`RESET_PC`.
  - `id_pc_o`=0, `id_inst_o`=0, `id_valid_o`=0.
  - `fault_o`=0, state=BOOT.

## Timing
- Fetch latency: a word addressed by `pc_o` in cycle N appears on `id_inst_o` after edge N (1 cycle).
- Reset release: `ce_o` rises after the first edge. The first valid `id_inst_o` (`RESET_PC`) appears after the second edge.
- Redirect: a branch or flush asserted in cycle N sets `pc_o`=target after edge N. The target instruction is valid in IF/ID after edge N+1, a 1-cycle bubble.
- Stall: one held cycle per stall cycle. No instruction is lost or duplicated across stall release.
- `ce_o` and `pc_o` come from registers, with no combinational path from any input. `fault_o` is registered.

## Structure
- Shared defines for this block:
  - `InstAddrBus`, `InstBus`, `ZeroDoubleWord`, `ChipEnable`, `ChipDisable`.
  - Reset-PC constant and FSM state encodings (BOOT/RUN/HALT).
- Natural sub-module: `if_id`, the IF/ID pipeline register. It has hold (stall), clear (squash/flush) and load.
- The PC, FSM, priority logic and fault logic stay in `if_fetch`.

## Test plan
- Reset then run with ROM words 0–4 -> `ce_o`=0 for one cycle after release. `id_inst_o` then shows 0x20808000000f0000, 0x2091000000002800, … on consecutive cycles, with `id_pc_o`=0x0, 0x8, 0x10, 0x18, 0x20.
- Stall for 3 cycles while `pc_o`=0x10 -> `pc_o`=0x10 and `id_pc_o`=0x8 held for 3 cycles. Next cycle `id_inst_o`=word 2; no skip or duplicate.
- Branch to 0x20 while `pc_o`=0x10 -> next cycle `id_valid_o`=0 and `pc_o`=0x20. The following cycle `id_pc_o`=0x20 and `id_valid_o`=1.
- Flush to 0x0, branch to 0x18 and stall all in the same cycle -> `pc_o`=0x0; flush wins.
- Branch to 0x0C -> `fault_o`=1 and `ce_o`=0 next cycle, holding indefinitely. Asserting `rst`=0 clears both asynchronously.
- Flush to 0xFFFFFFF8 with 2 free-run cycles -> `pc_o`=0x0 after wrap. Also assert `rst` low mid-stall -> all outputs return to reset values immediately.
